// File: rtl/dds_sweep_pkg.sv
// rtl/dds_sweep_pkg.sv - shared widths, state encoding and direction constants for the DDS sweep controller
package dds_sweep_pkg;

    localparam int FW_DEF = 24;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DWELL_UP = 2'd1,
        ST_DWELL_DN = 2'd2,
        ST_DONE     = 2'd3
    } sweep_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - counts timebase ticks and flags the tick that completes a dwell
module sweep_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          tick_in,
    input  logic          clear_in,
    input  logic [DW-1:0] limit_in,
    output logic          expire_out
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_last;
    logic          w_expire;

    // A zero limit behaves as a one-tick dwell.
    assign w_last     = (limit_in == '0) ? '0 : (limit_in - ONE);
    assign w_expire   = tick_in && !clear_in && (r_cnt == w_last);
    assign expire_out = w_expire;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
        end else if (clear_in) begin
            r_cnt <= '0;
        end else if (tick_in) begin
            r_cnt <= w_expire ? '0 : (r_cnt + ONE);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency sweep sequencer driving a DDS/timer f0 word, up-ramp or triangle
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic          abort_in,
    input  logic [FW-1:0] f_start_in,
    input  logic [FW-1:0] f_stop_in,
    input  logic [FW-1:0] f_step_in,
    input  logic [DW-1:0] dwell_in,
    input  logic          bidir_in,
    input  logic          tick_in,
    output logic [FW-1:0] f0_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          step_out,
    output logic          err_out
);

    sweep_state_t  r_state;
    sweep_state_t  w_state_nxt;

    logic [FW-1:0] r_f_start;
    logic [FW-1:0] r_f_stop;
    logic [FW-1:0] r_f_step;
    logic [DW-1:0] r_dwell;
    logic          r_bidir;

    logic [FW-1:0] r_f0;
    logic [FW-1:0] w_f0_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_step;
    logic          w_step_nxt;
    logic          r_err;
    logic          w_err_nxt;

    logic          w_start_ok;
    logic          w_accept;
    logic          w_reject;
    logic          w_dwelling;
    logic          w_tick_en;
    logic          w_clear;
    logic          w_expire;
    logic          w_at_stop;
    logic          w_at_start;
    logic          w_move_dir;
    logic [FW:0]   w_sum;
    logic [FW:0]   w_diff;
    logic [FW-1:0] w_f_up;
    logic [FW-1:0] w_f_dn;
    logic [FW-1:0] w_f_move;

    assign w_start_ok = (f_step_in != '0) && (f_start_in <= f_stop_in);
    assign w_accept   = (r_state == ST_IDLE) && start_in && !abort_in && w_start_ok;
    assign w_reject   = (r_state == ST_IDLE) && start_in && !abort_in && !w_start_ok;

    assign w_dwelling = (r_state == ST_DWELL_UP) || (r_state == ST_DWELL_DN);
    assign w_tick_en  = w_dwelling && tick_in && !abort_in;
    assign w_clear    = !w_dwelling || abort_in;

    sweep_dwell_timer #(
        .DW (DW)
    ) u_dwell (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .tick_in    (w_tick_en),
        .clear_in   (w_clear),
        .limit_in   (r_dwell),
        .expire_out (w_expire)
    );

    // One extra bit on both sides so a carry or borrow clamps to the bound instead of wrapping.
    assign w_sum  = {1'b0, r_f0} + {1'b0, r_f_step};
    assign w_diff = {1'b0, r_f0} - {1'b0, r_f_step};
    assign w_f_up = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[FW-1:0];
    assign w_f_dn = (w_diff[FW] || (w_diff[FW-1:0] < r_f_start)) ? r_f_start : w_diff[FW-1:0];

    assign w_at_stop  = (r_f0 >= r_f_stop);
    assign w_at_start = (r_f0 <= r_f_start);

    // Reaching the top of an up-ramp turns the next move downward.
    assign w_move_dir = ((r_state == ST_DWELL_DN) || w_at_stop) ? DIR_DN : DIR_UP;
    assign w_f_move   = (w_move_dir == DIR_UP) ? w_f_up : w_f_dn;

    always_comb begin
        w_state_nxt = r_state;
        w_f0_nxt    = r_f0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = ST_DWELL_UP;
                    w_f0_nxt    = f_start_in;
                    w_busy_nxt  = 1'b1;
                    w_step_nxt  = 1'b1;
                end else if (w_reject) begin
                    w_err_nxt = 1'b1;
                end
            end

            ST_DWELL_UP: begin
                if (abort_in) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_expire) begin
                    if (!w_at_stop) begin
                        w_f0_nxt   = w_f_move;
                        w_step_nxt = 1'b1;
                    end else if (r_bidir) begin
                        w_state_nxt = ST_DWELL_DN;
                        w_f0_nxt    = w_f_move;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            ST_DWELL_DN: begin
                if (abort_in) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_expire) begin
                    if (!w_at_start) begin
                        w_f0_nxt   = w_f_move;
                        w_step_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= ST_IDLE;
            r_f0      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_bidir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_f0    <= w_f0_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_step  <= w_step_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_f_start <= f_start_in;
                r_f_stop  <= f_stop_in;
                r_f_step  <= f_step_in;
                r_dwell   <= dwell_in;
                r_bidir   <= bidir_in;
            end
        end
    end

    assign f0_out   = r_f0;
    assign busy_out = r_busy;
    assign done_out = r_done;
    assign step_out = r_step;
    assign err_out  = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl against a sequence-level sweep model
module tb_dds_sweep_ctrl;

    localparam int FW = 24;
    localparam int DW = 16;

    logic          clk_in     = 1'b0;
    logic          rst_in     = 1'b0;
    logic          start_in   = 1'b0;
    logic          abort_in   = 1'b0;
    logic [FW-1:0] f_start_in = '0;
    logic [FW-1:0] f_stop_in  = '0;
    logic [FW-1:0] f_step_in  = '0;
    logic [DW-1:0] dwell_in   = '0;
    logic          bidir_in   = 1'b0;
    logic          tick_in    = 1'b0;
    logic [FW-1:0] f0_out;
    logic          busy_out;
    logic          done_out;
    logic          step_out;
    logic          err_out;

    int checks   = 0;
    int failures = 0;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .abort_in   (abort_in),
        .f_start_in (f_start_in),
        .f_stop_in  (f_stop_in),
        .f_step_in  (f_step_in),
        .dwell_in   (dwell_in),
        .bidir_in   (bidir_in),
        .tick_in    (tick_in),
        .f0_out     (f0_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .step_out   (step_out),
        .err_out    (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tick generator: one tick every tick_period cycles, off when zero.
    int tick_period = 0;
    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk_in);
            if (tick_period > 0) begin
                ph = (ph + 1 >= tick_period) ? 0 : ph + 1;
                tick_in = (ph == 0);
            end else begin
                ph = 0;
                tick_in = 1'b0;
            end
        end
    end

    // Ticks that land while a sweep is dwelling.
    int tick_total = 0;
    always @(posedge clk_in) begin
        if (rst_in && busy_out && tick_in && !abort_in)
            tick_total <= tick_total + 1;
    end

    // Model: the full list of frequencies a sweep must visit.
    longint exp_q[$];
    int     m_dwell = 1;
    bit     m_armed = 1'b0;

    function automatic void build_seq(input longint s, input longint e, input longint st, input bit bd);
        longint f;
        exp_q.delete();
        f = s;
        exp_q.push_back(f);
        while (f < e) begin
            f = (f + st > e) ? e : f + st;
            exp_q.push_back(f);
        end
        if (bd) begin
            do begin
                f = (f - st < s) ? s : f - st;
                exp_q.push_back(f);
            end while (f > s);
        end
    endfunction

    int     step_cnt = 0;
    int     done_cnt = 0;
    int     err_cnt  = 0;
    longint obs_q[$];

    initial begin : compare
        int            m_idx;
        bit            m_run;
        bit            m_fin;
        int            mark;
        logic [FW-1:0] last_f0;
        m_idx = 0; m_run = 0; m_fin = 0; mark = 0; last_f0 = '0;
        forever begin
            @(negedge clk_in);
            if (step_out) begin
                step_cnt++;
                obs_q.push_back(longint'(f0_out));
            end
            if (done_out) done_cnt++;
            if (err_out)  err_cnt++;
            if (!m_armed) begin
                m_idx = 0; m_run = 0; m_fin = 0;
            end else if (!m_fin) begin
                if (step_out) begin
                    if (m_idx >= exp_q.size())
                        chk("step_count", m_idx + 1, exp_q.size());
                    else
                        chk("f0_seq", longint'(f0_out), exp_q[m_idx]);
                    if (m_run) chk("dwell_ticks", tick_total - mark, m_dwell);
                    mark  = tick_total;
                    m_run = 1;
                    m_idx++;
                end else if (m_run) begin
                    chk("f0_hold", longint'(f0_out), longint'(last_f0));
                end
                if (m_run) begin
                    if (done_out) begin
                        chk("done_len", m_idx, exp_q.size());
                        chk("done_ticks", tick_total - mark, m_dwell);
                        chk("done_busy", busy_out, 0);
                        m_fin = 1;
                    end else begin
                        chk("busy", busy_out, 1);
                    end
                end
            end
            last_f0 = f0_out;
        end
    end

    task automatic start_sweep(input logic [FW-1:0] s, input logic [FW-1:0] e, input logic [FW-1:0] st,
                               input logic [DW-1:0] dw, input bit bd, input bit expect_ok);
        @(negedge clk_in);
        f_start_in = s;
        f_stop_in  = e;
        f_step_in  = st;
        dwell_in   = dw;
        bidir_in   = bd;
        if (expect_ok) begin
            build_seq(longint'(s), longint'(e), longint'(st), bd);
            m_dwell = (dw == 0) ? 1 : int'(dw);
            m_armed = 1'b1;
        end
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic disarm();
        @(negedge clk_in);
        m_armed = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, done_cnt - d0, 1);
    endtask

    task automatic wait_steps(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (step_cnt < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, step_cnt >= target, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    longint ramp_lit[4] = '{100, 110, 120, 130};
    longint tri_lit[5]  = '{10, 25, 30, 15, 10};

    initial begin : main
        int s0;
        int d0;
        int e0;

        // Reset state
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_f0", f0_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_step", step_out, 0);
        chk("rst_err", err_out, 0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Up-ramp, with config changes and a second start while busy
        tick_period = 4;
        s0 = step_cnt; d0 = done_cnt;
        start_sweep(24'd100, 24'd130, 24'd10, 16'd2, 1'b0, 1'b1);
        chk("ramp_model_len", exp_q.size(), 4);
        chk("ramp_model_last", exp_q[3], 130);
        @(negedge clk_in);
        f_step_in = 24'd1; f_stop_in = 24'd1000; bidir_in = 1'b1; dwell_in = 16'd7; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_done("ramp_done", 1000);
        chk("ramp_f0_final", f0_out, 130);
        chk("ramp_busy_after", busy_out, 0);
        chk("ramp_steps", step_cnt - s0, 4);
        for (int i = 0; i < 4; i++) chk("ramp_obs", obs_q[s0 + i], ramp_lit[i]);
        @(negedge clk_in);
        chk("ramp_done_pulse", done_out, 0);
        chk("ramp_done_count", done_cnt - d0, 1);
        disarm();

        // Saturation near the top of the word, dwell 0 acting as 1
        tick_period = 3;
        s0 = step_cnt;
        start_sweep(24'hFFFFF0, 24'hFFFFFF, 24'h000020, 16'd0, 1'b0, 1'b1);
        chk("sat_model_len", exp_q.size(), 2);
        chk("sat_model_last", exp_q[1], 64'hFFFFFF);
        wait_done("sat_done", 1000);
        chk("sat_f0_final", f0_out, 64'hFFFFFF);
        chk("sat_steps", step_cnt - s0, 2);
        disarm();

        // Triangle
        tick_period = 2;
        s0 = step_cnt;
        start_sweep(24'd10, 24'd30, 24'd15, 16'd1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) chk("tri_model", exp_q[i], tri_lit[i]);
        wait_done("tri_done", 1000);
        for (int i = 0; i < 5; i++) chk("tri_obs", obs_q[s0 + i], tri_lit[i]);
        chk("tri_f0_final", f0_out, 10);
        disarm();

        // Degenerate start equal to stop, triangle mode
        s0 = step_cnt;
        start_sweep(24'd77, 24'd77, 24'd5, 16'd1, 1'b1, 1'b1);
        wait_done("flat_done", 1000);
        chk("flat_steps", step_cnt - s0, 2);
        chk("flat_f0", f0_out, 77);
        disarm();

        // Rejected starts
        e0 = err_cnt; s0 = step_cnt;
        start_sweep(24'd50, 24'd60, 24'd0, 16'd1, 1'b0, 1'b0);
        chk("rej0_err", err_out, 1);
        chk("rej0_busy", busy_out, 0);
        chk("rej0_f0", f0_out, 77);
        @(negedge clk_in);
        chk("rej0_err_pulse", err_out, 0);
        start_sweep(24'd50, 24'd40, 24'd5, 16'd1, 1'b0, 1'b0);
        chk("rej1_err", err_out, 1);
        chk("rej1_busy", busy_out, 0);
        chk("rej1_f0", f0_out, 77);
        repeat (3) @(negedge clk_in);
        chk("rej_err_count", err_cnt - e0, 2);
        chk("rej_no_step", step_cnt - s0, 0);

        // Abort beats start in idle
        @(negedge clk_in);
        f_start_in = 24'd5; f_stop_in = 24'd9; f_step_in = 24'd1; abort_in = 1'b1; start_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0; start_in = 1'b0;
        chk("abst_step", step_out, 0);
        chk("abst_busy", busy_out, 0);
        chk("abst_err", err_out, 0);
        chk("abst_f0", f0_out, 77);

        // Abort during the second dwell of the up-ramp, then a fresh sweep
        tick_period = 4;
        s0 = step_cnt; d0 = done_cnt;
        start_sweep(24'd100, 24'd130, 24'd10, 16'd2, 1'b0, 1'b1);
        wait_steps("abort_reach", s0 + 2, 200);
        @(negedge clk_in);
        m_armed = 1'b0;
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("abort_busy", busy_out, 0);
        chk("abort_f0", f0_out, 110);
        repeat (20) @(negedge clk_in);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_hold_f0", f0_out, 110);
        start_sweep(24'd100, 24'd130, 24'd10, 16'd2, 1'b0, 1'b1);
        wait_done("abort_restart_done", 1000);
        chk("abort_restart_f0", f0_out, 130);
        disarm();

        // Reset while stepping down
        tick_period = 3;
        s0 = step_cnt; d0 = done_cnt;
        start_sweep(24'd10, 24'd30, 24'd15, 16'd2, 1'b1, 1'b1);
        wait_steps("rstmid_reach", s0 + 4, 400);
        @(negedge clk_in);
        m_armed = 1'b0;
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        chk("rstmid_f0", f0_out, 0);
        chk("rstmid_busy", busy_out, 0);
        chk("rstmid_done", done_out, 0);
        chk("rstmid_step", step_out, 0);
        chk("rstmid_err", err_out, 0);
        repeat (15) @(negedge clk_in);
        chk("rstmid_no_done", done_cnt - d0, 0);
        start_sweep(24'd100, 24'd130, 24'd10, 16'd1, 1'b0, 1'b1);
        wait_done("rstmid_restart_done", 1000);
        chk("rstmid_restart_f0", f0_out, 130);
        disarm();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
